// File: rtl/psram_burst_arbiter.sv
// psram_burst_arbiter: shares one PSRAM controller command port between the
// camera frame writer (W) and the display frame reader (R). Round-robin
// arbitration with one burst in flight at a time. After each command the
// controller's burst delay is waited out before the next arbitration.
module psram_burst_arbiter #(
  parameter int BURST      = 16,
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_calib,
  input  logic                  w_req,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ack,
  output logic                  w_data_req,
  input  logic                  r_req,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_ack,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  cmd,
  output logic                  cmd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  output logic                  busy,
  output logic                  rd_err
);

  // Controller post-command delay for each legal burst length
  function automatic int burst_delay(input int b);
    case (b)
      16:      return 15;
      32:      return 19;
      64:      return 27;
      128:     return 43;
      default: return 0;
    endcase
  endfunction

  localparam int BEATS = BURST / 4;
  localparam int DELAY = burst_delay(BURST);

  localparam logic [7:0] BEATS_C   = 8'(BEATS);
  localparam logic [7:0] BEATS_M1  = 8'(BEATS - 1);
  localparam logic [7:0] DELAY_C   = 8'(DELAY);

  if (!(BURST == 16 || BURST == 32 || BURST == 64 || BURST == 128)) begin : g_illegal_burst
    $error("psram_burst_arbiter: BURST must be 16, 32, 64 or 128");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    CMD  = 2'd2,
    BUSY = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_w_q, last_w_d;     // 1: last grant went to W
  logic                  grant_w_q, grant_w_d;   // 1: current burst belongs to W
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;           // post-command delay
  logic [7:0]            wbeat_q, wbeat_d;       // remaining write beats after CMD
  logic [7:0]            rbeat_q, rbeat_d;       // read beats seen so far
  logic                  rd_err_q, rd_err_d;

  logic                  pick_w;
  logic                  read_active;
  logic [7:0]            rbeat_inc;

  // W wins unless R is also waiting and W had the previous grant
  assign pick_w      = w_req && (!r_req || !last_w_q);
  assign read_active = ((state_q == CMD) || (state_q == BUSY)) && !grant_w_q;
  assign rbeat_inc   = rbeat_q + {7'd0, rd_data_valid};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_w_q  <= 1'b0;
      grant_w_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wbeat_q   <= '0;
      rbeat_q   <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_w_q  <= last_w_d;
      grant_w_q <= grant_w_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wbeat_q   <= wbeat_d;
      rbeat_q   <= rbeat_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Next-state logic: arbitration, delay countdown and beat bookkeeping
  always_comb begin
    state_d   = state_q;
    last_w_d  = last_w_q;
    grant_w_d = grant_w_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wbeat_d   = wbeat_q;
    rbeat_d   = rbeat_q;
    rd_err_d  = rd_err_q;
    case (state_q)
      IDLE: begin
        if (init_calib) state_d = ARB;
      end
      ARB: begin
        if (!init_calib) begin
          state_d = IDLE;
        end else if (w_req || r_req) begin
          grant_w_d = pick_w;
          addr_d    = pick_w ? w_addr : r_addr;
          state_d   = CMD;
        end
      end
      CMD: begin
        last_w_d = grant_w_q;
        cnt_d    = DELAY_C;
        wbeat_d  = grant_w_q ? BEATS_M1 : 8'd0;
        rbeat_d  = read_active ? {7'd0, rd_data_valid} : 8'd0;
        state_d  = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (wbeat_q != 8'd0) wbeat_d = wbeat_q - 8'd1;
        if (read_active) rbeat_d = rbeat_inc;
        if (cnt_q == 8'd1) begin
          state_d = init_calib ? ARB : IDLE;
          if (read_active && (rbeat_inc != BEATS_C)) rd_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state and latched grant
  always_comb begin
    cmd_en     = (state_q == CMD);
    cmd        = cmd_en && grant_w_q;
    addr       = cmd_en ? addr_q : '0;
    w_ack      = cmd_en && grant_w_q;
    r_ack      = cmd_en && !grant_w_q;
    w_data_req = grant_w_q &&
                 ((state_q == CMD) || ((state_q == BUSY) && (wbeat_q != 8'd0)));
    wr_data    = w_data_req ? w_data : '0;
    r_valid    = read_active && rd_data_valid;
    r_data     = read_active ? rd_data : '0;
    busy       = (state_q != ARB);
    rd_err     = rd_err_q;
  end

endmodule

// File: tb/tb_psram_burst_arbiter.sv
// tb_psram_burst_arbiter: scoreboard bench for psram_burst_arbiter with
// BURST=16 (4 beats, delay 15, command spacing 17). Expected commands and
// read beats are queued when stimulus is driven and popped by a monitor.
module tb_psram_burst_arbiter;

  localparam int BURST   = 16;
  localparam int AW      = 21;
  localparam int DW      = 32;
  localparam int BEATS   = 4;
  localparam int DELAY   = 15;
  localparam int SPACING = 17;

  logic          clk;
  logic          reset;
  logic          init_calib;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_ack;
  logic          w_data_req;
  logic          r_req;
  logic [AW-1:0] r_addr;
  logic          r_ack;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          cmd;
  logic          cmd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          busy;
  logic          rd_err;

  psram_burst_arbiter #(
    .BURST(BURST), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .init_calib(init_calib),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
    .w_ack(w_ack), .w_data_req(w_data_req),
    .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack),
    .r_data(r_data), .r_valid(r_valid),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .busy(busy), .rd_err(rd_err)
  );

  typedef struct packed {
    logic          isWrite;
    logic [AW-1:0] addr;
  } cmd_t;

  cmd_t          expCmd[$];
  logic [DW-1:0] expRd[$];

  int   errorCount = 0;
  int   checkCount = 0;
  int   cycle      = 0;
  int   cmdSeen    = 0;
  bit   spacingOn  = 0;
  bit   shortBurst = 0;

  int   prevCycle  = 0;
  bit   prevValid  = 0;
  int   runLen     = 0;
  cmd_t monE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Fresh writer data every cycle so pass-through is visible
  initial begin
    w_data = 32'h1234_5678;
    forever begin
      @(posedge clk);
      #1 w_data = $urandom;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errorCount);
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pushCmd(input bit isWrite, input logic [AW-1:0] a);
    cmd_t e;
    e.isWrite = isWrite;
    e.addr    = a;
    expCmd.push_back(e);
  endtask

  task automatic applyStimulus(input bit wr, input bit rr,
                               input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    w_req  = wr;
    r_req  = rr;
    w_addr = wa;
    r_addr = ra;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(posedge clk);
      if (expCmd.size() == 0) break;
    end
    checkOutput("cmd_queue_drained", expCmd.size(), 0);
  endtask

  task automatic waitCmd(input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (cmd_en) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("cmd_seen", seen, 1);
  endtask

  // Controller model: answers each read command with BEATS (or BEATS-1) beats
  initial begin
    rd_data_valid = 1'b0;
    rd_data       = '0;
    forever begin
      @(negedge clk);
      if (!reset && cmd_en && !cmd) begin
        int n;
        n = shortBurst ? BEATS - 1 : BEATS;
        repeat (3) @(posedge clk);
        for (int i = 0; i < n; i++) begin
          #1;
          rd_data_valid = 1'b1;
          rd_data       = $urandom;
          expRd.push_back(rd_data);
          @(posedge clk);
        end
        #1 rd_data_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expected commands and read beats, checks spacing and write beats
  always @(negedge clk) begin
    if (reset) begin
      prevValid = 1'b0;
      runLen    = 0;
    end else begin
      if (!spacingOn) prevValid = 1'b0;
      if (cmd_en) begin
        cmdSeen++;
        if (expCmd.size() == 0) begin
          checkOutput("cmd_unexpected", 1, 0);
        end else begin
          monE = expCmd.pop_front();
          checkOutput("cmd_type", cmd, monE.isWrite);
          checkOutput("cmd_addr", addr, monE.addr);
          checkOutput("w_ack", w_ack, monE.isWrite);
          checkOutput("r_ack", r_ack, !monE.isWrite);
          if (monE.isWrite) checkOutput("wdreq_on_cmd", w_data_req, 1);
        end
        if (spacingOn && prevValid) checkOutput("cmd_spacing", cycle - prevCycle, SPACING);
        prevValid = 1'b1;
        prevCycle = cycle;
      end else if (w_ack || r_ack) begin
        checkOutput("ack_stray", 1, 0);
      end
      if (w_data_req) begin
        runLen++;
        checkOutput("wr_data", wr_data, w_data);
      end else begin
        if (runLen > 0) checkOutput("wdreq_len", runLen, BEATS);
        runLen = 0;
        if (wr_data != '0) checkOutput("wr_data_idle", wr_data, 0);
      end
      if (r_valid) begin
        if (expRd.size() == 0) checkOutput("r_valid_stray", 1, 0);
        else checkOutput("r_data", r_data, expRd.pop_front());
      end
    end
  end

  // Main sequence
  initial begin
    int snap;
    reset      = 1'b1;
    init_calib = 1'b0;
    applyStimulus(0, 0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_en", cmd_en, 0);
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_w_ack", w_ack, 0);
    checkOutput("rst_r_ack", r_ack, 0);
    checkOutput("rst_wdreq", w_data_req, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_r_valid", r_valid, 0);
    checkOutput("rst_rd_err", rd_err, 0);
    checkOutput("rst_busy_idle", busy, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // No command while uncalibrated; stray controller beat ignored
    applyStimulus(1, 0, 21'h000100, '0);
    snap = cmdSeen;
    repeat (100) @(posedge clk);
    #1 rd_data_valid = 1'b1;
    rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("r_valid_ignored", r_valid, 0);
    @(posedge clk);
    #1 rd_data_valid = 1'b0;
    checkOutput("no_cmd_uncal", cmdSeen - snap, 0);

    // Calibration rises: command two cycles later, then back-to-back writes
    repeat (4) pushCmd(1, 21'h000100);
    spacingOn = 1'b1;
    @(posedge clk);
    #1 init_calib = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("calib_cmd_en", cmd_en, 1);
    checkOutput("calib_cmd_wr", cmd, 1);
    waitDrain(100);
    #1 applyStimulus(0, 0, '0, '0);
    spacingOn = 1'b0;
    repeat (20) @(posedge clk);

    // Both requesters continuous: W first after reset, then alternate
    applyReset();
    applyStimulus(1, 1, 21'h000200, 21'h000300);
    pushCmd(1, 21'h000200);
    pushCmd(0, 21'h000300);
    pushCmd(1, 21'h000200);
    pushCmd(0, 21'h000300);
    spacingOn = 1'b1;
    waitDrain(150);
    #1 applyStimulus(0, 0, '0, '0);
    spacingOn = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("rd_err_full_bursts", rd_err, 0);

    // Short read burst sets rd_err when BUSY ends, and it stays set
    shortBurst = 1'b1;
    pushCmd(0, 21'h000400);
    @(posedge clk);
    #1 applyStimulus(0, 1, '0, 21'h000400);
    waitDrain(20);
    #1 r_req = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    checkOutput("rd_err_before_end", rd_err, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rd_err_set", rd_err, 1);
    shortBurst = 1'b0;
    pushCmd(0, 21'h000480);
    @(posedge clk);
    #1 applyStimulus(0, 1, '0, 21'h000480);
    waitDrain(20);
    #1 r_req = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("rd_err_sticky", rd_err, 1);

    // Reset in the middle of a write burst
    pushCmd(1, 21'h000500);
    @(posedge clk);
    #1 applyStimulus(1, 0, 21'h000500, '0);
    waitCmd(30);
    @(posedge clk);
    #1 w_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_cmd_en", cmd_en, 0);
    checkOutput("midrst_wdreq", w_data_req, 0);
    checkOutput("midrst_wr_data", wr_data, 0);
    checkOutput("midrst_busy_idle", busy, 1);
    checkOutput("midrst_rd_err", rd_err, 0);
    @(negedge clk);
    checkOutput("midrst_then_arb", busy, 0);

    // Brief calibration drop inside BUSY does not disturb spacing
    pushCmd(1, 21'h000600);
    pushCmd(1, 21'h000600);
    spacingOn = 1'b1;
    @(posedge clk);
    #1 applyStimulus(1, 0, 21'h000600, '0);
    waitCmd(30);
    @(posedge clk);
    @(posedge clk);
    #1 init_calib = 1'b0;
    repeat (3) @(posedge clk);
    #1 init_calib = 1'b1;
    waitDrain(40);

    // Calibration lost during BUSY: full delay, then IDLE, no new command
    #1 init_calib = 1'b0;
    applyStimulus(1, 1, 21'h000600, 21'h000680);
    spacingOn = 1'b0;
    snap = cmdSeen;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("calib_drop_idle", busy, 1);
    repeat (40) @(posedge clk);
    checkOutput("calib_drop_no_cmd", cmdSeen - snap, 0);
    pushCmd(0, 21'h000680);
    @(posedge clk);
    #1 init_calib = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("recal_cmd_en", cmd_en, 1);
    checkOutput("recal_cmd_rd", cmd, 0);
    @(posedge clk);
    #1 applyStimulus(0, 0, '0, '0);
    repeat (30) @(posedge clk);

    checkOutput("cmd_queue_empty", expCmd.size(), 0);
    checkOutput("rd_queue_empty", expRd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
